pipe_stage_skid_reg: RTL and testbench

PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

---
 rtl/pipe_stage_skid_reg_if.sv | 25 ++
 rtl/pipe_stage_skid_reg.sv | 132 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready handshake bundle around one pipeline stage: upstream in_* side and
// downstream out_* side. The stage uses the slave view; its environment uses master.
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Two-entry skid-buffered pipeline register (falling-edge clocked). in_ready and
// out_valid come straight from flops so no ready path crosses the stage.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_skid_reg_if.slave bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, out_valid_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [CNT_W-1:0]  stall_q;

  logic accept, fire;
  logic load_main_in, load_main_skid, load_skid_in, clr_main_ctrl;

  assign accept = bus.in_valid & in_ready_q;
  assign fire   = out_valid_q & bus.out_ready;

  // State register, plus the handshake flags precomputed from the next state
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != SKID);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // Next-state and datapath steering
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    clr_main_ctrl  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (fire && accept) begin
          load_main_in = 1'b1;
        end else if (fire) begin
          state_d       = EMPTY;
          clr_main_ctrl = 1'b1;
        end else if (accept) begin
          state_d      = SKID;
          load_skid_in = 1'b1;
        end
      end
      SKID: begin
        if (fire) begin
          state_d        = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Output decode
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Payload registers; flush squashes control only, data is left as a don't-care bubble
  always_ff @(negedge clk) begin
    if (reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (load_main_in) begin
        main_data_q <= bus.in_data;
        main_ctrl_q <= bus.in_ctrl;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
        skid_ctrl_q <= '0;
      end else if (clr_main_ctrl) begin
        main_ctrl_q <= '0;
      end
      if (load_skid_in) begin
        skid_data_q <= bus.in_data;
        skid_ctrl_q <= bus.in_ctrl;
      end
    end
  end

  // Stall counter ignores flush so back-pressure statistics survive a squash
  always_ff @(negedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid_q && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a reference FIFO of accepted entries is
// compared against the stage outputs every cycle, between falling edges.
module tb_pipe_stage_skid_reg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  ent_t             sb_q[$];
  logic [CNT_W-1:0] exp_stall;
  int               n_checks;
  int               n_pass;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock: check outputs mid-cycle, drive inputs, advance the model, wait for the edge
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                     input logic ordy, input logic fl, input logic rs);
    int   occ;
    logic fire_m, acc_m;
    ent_t e;
    @(posedge clk);
    #1;
    occ = sb_q.size();
    check_eq("occupancy", 64'(occupancy), 64'(occ));
    check_eq("in_ready", 64'(bus.in_ready), 64'(occ < 2));
    check_eq("out_valid", 64'(bus.out_valid), 64'(occ > 0));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    if (occ > 0) begin
      check_eq("out_data", 64'(bus.out_data), 64'(sb_q[0].d));
      check_eq("out_ctrl", 64'(bus.out_ctrl), 64'(sb_q[0].c));
    end else begin
      check_eq("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
    end
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rs;
    if (rs) begin
      sb_q.delete();
      exp_stall = '0;
    end else begin
      fire_m = (occ > 0) && ordy;
      acc_m  = v && (occ < 2);
      if ((occ > 0) && !ordy && (exp_stall != CNT_MAX)) exp_stall = exp_stall + 1'b1;
      if (fl) begin
        sb_q.delete();
      end else begin
        if (fire_m) void'(sb_q.pop_front());
        if (acc_m) begin
          e.d = d;
          e.c = c;
          sb_q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    exp_stall     = '0;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, including the retained data register
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("rst_data", 64'(bus.out_data), 64'd0);
    check_eq("rst_ctrl", 64'(bus.out_ctrl), 64'd0);

    // First entry after reset: one-edge latency
    cyc(1'b1, 32'h11, 8'h05, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("lat_valid", 64'(bus.out_valid), 64'd1);
    check_eq("lat_data", 64'(bus.out_data), 64'h11);
    idle(1'b1);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) cyc(1'b1, DATA_W'(i), CTRL_W'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: fill the skid, hold off 0xA3, then drain in order
    cyc(1'b1, 32'hA1, 8'h21, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA2, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA3, 8'h23, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA3, 8'h23, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hA3, 8'h23, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush while in SKID with a same-cycle input
    cyc(1'b1, 32'hB1, 8'h31, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB2, 8'h32, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD, 8'h7F, 1'b0, 1'b1, 1'b0);
    #1;
    check_eq("flush_occ", 64'(occupancy), 64'd0);
    check_eq("flush_ready", 64'(bus.in_ready), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Reset while in SKID discards both entries
    cyc(1'b1, 32'hC1, 8'h41, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC2, 8'h42, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC3, 8'h43, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Stall counter saturation
    cyc(1'b1, 32'hE1, 8'h51, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) idle(1'b0);
    #1;
    check_eq("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random handshakes with occasional flush and reset
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), DATA_W'($urandom), CTRL_W'($urandom),
          1'($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 999) == 0));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
